nn_mlp_seq: RTL and testbench

- Time-multiplexed two-layer MLP inference engine. Successor to the fully parallel two-layer network.
- A single MAC is shared by all neurons. Inputs arrive as a valid/ready stream; weights and biases come from an external synchronous memory port.
- Hidden layer applies ReLU with requantisation. Output layer is linear, full accumulator width, streamed out with valid/ready.
- Sits between the feature-input buffer and the classifier/readout logic.

---
 rtl/nn_mlp_seq_if.sv | 45 ++++
 rtl/nn_mlp_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_nn_mlp_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_mlp_seq_if.sv
// Bus of the nn_mlp_seq engine: input stream, weight memory port, result stream.
// The argmax signals are present only when NN_ARGMAX_EN is defined.
interface nn_mlp_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int WADDR_W    = 13
`ifdef NN_ARGMAX_EN
  ,
  parameter int IDX_W      = 4
`endif
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  w_rd_en;
  logic [WADDR_W-1:0]    w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  out_last;
  logic                  busy;
`ifdef NN_ARGMAX_EN
  logic                  argmax_valid;
  logic [IDX_W-1:0]      argmax_idx;
`endif

  // Engine side.
  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_rd_en, w_addr, out_valid, out_data, out_last, busy
`ifdef NN_ARGMAX_EN
    , argmax_valid, argmax_idx
`endif
  );

  // Feature buffer, weight memory and readout side.
  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_rd_en, w_addr, out_valid, out_data, out_last, busy
`ifdef NN_ARGMAX_EN
    , argmax_valid, argmax_idx
`endif
  );
endinterface

// File: rtl/nn_mlp_seq.sv
// Time-multiplexed two-layer MLP: one shared MAC, streamed inputs/outputs, external weight memory.
// Define NN_ARGMAX_EN to add the argmax_valid/argmax_idx result of the output layer.
module nn_mlp_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int IN_NUM     = 784,
  parameter int HID_NUM    = 10,
  parameter int OUT_NUM    = 10,
  parameter int WADDR_W    = $clog2(HID_NUM*(IN_NUM+1) + OUT_NUM*(HID_NUM+1))
) (
  input  logic        clk,
  input  logic        rst,
  nn_mlp_seq_if.slave bus
);
  localparam int MAX_TAPS = (IN_NUM > HID_NUM) ? IN_NUM : HID_NUM;
  localparam int MAX_NEU  = (HID_NUM > OUT_NUM) ? HID_NUM : OUT_NUM;
  localparam int TAP_W    = $clog2(MAX_TAPS + 2);
  localparam int NEU_W    = (MAX_NEU > 1) ? $clog2(MAX_NEU) : 1;
  localparam int IN_IW    = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int HID_IW   = (HID_NUM > 1) ? $clog2(HID_NUM) : 1;
  localparam int OUT_IW   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

  localparam logic [TAP_W-1:0]  L1_FIN       = TAP_W'(IN_NUM + 1);
  localparam logic [TAP_W-1:0]  L2_FIN       = TAP_W'(HID_NUM + 1);
  localparam logic [NEU_W-1:0]  HID_LAST     = NEU_W'(HID_NUM - 1);
  localparam logic [NEU_W-1:0]  OUT_LAST     = NEU_W'(OUT_NUM - 1);
  localparam logic [IN_IW-1:0]  IN_LAST      = IN_IW'(IN_NUM - 1);
  localparam logic [OUT_IW-1:0] OUT_IDX_LAST = OUT_IW'(OUT_NUM - 1);
  localparam logic signed [ACC_WIDTH-1:0] HID_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_L1, S_L2, S_OUT} state_t;

  state_t state_q, state_d;

  logic                         in_ready_q;
  logic [IN_IW-1:0]             in_cnt_q;
  logic [TAP_W-1:0]             tap_q;
  logic [NEU_W-1:0]             neu_q;
  logic [OUT_IW-1:0]            out_cnt_q;
  logic [WADDR_W-1:0]           ptr_q;
  logic [WADDR_W-1:0]           last_addr_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic                         out_valid_q;
  logic [ACC_WIDTH-1:0]         out_data_q;
  logic                         out_last_q;

  logic signed [DATA_WIDTH-1:0] in_buf  [IN_NUM];
  logic signed [DATA_WIDTH-1:0] hid_buf [HID_NUM];
  logic signed [ACC_WIDTH-1:0]  out_buf [OUT_NUM];

  logic                         accept;
  logic                         last_in;
  logic                         in_layer;
  logic                         fetch;
  logic                         fin;
  logic                         layer_done;
  logic                         out_fire;
  logic [TAP_W-1:0]             fin_tap;
  logic [NEU_W-1:0]             layer_last;

  logic [IN_IW-1:0]             in_idx;
  logic [HID_IW-1:0]            hid_idx;
  logic [OUT_IW-1:0]            out_nxt;
  logic signed [DATA_WIDTH-1:0] operand;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [DATA_WIDTH-1:0] hid_act;

  assign last_in    = (in_cnt_q == IN_LAST);
  assign in_layer   = (state_q == S_L1) || (state_q == S_L2);
  assign fin_tap    = (state_q == S_L2) ? L2_FIN : L1_FIN;
  assign layer_last = (state_q == S_L2) ? OUT_LAST : HID_LAST;
  assign out_nxt    = out_cnt_q + 1'b1;

  // Tap t (1..N) multiplies the weight fetched at tap t-1 with operand t-1.
  assign in_idx   = IN_IW'(tap_q - 1'b1);
  assign hid_idx  = HID_IW'(tap_q - 1'b1);
  assign operand  = (state_q == S_L2) ? hid_buf[hid_idx] : in_buf[in_idx];
  assign prod     = operand * $signed(bus.w_data);
  assign prod_ext = ACC_WIDTH'(prod);
  assign bias_ext = ACC_WIDTH'($signed(bus.w_data)) <<< FRAC_BITS;
  assign sum      = acc_q + bias_ext;
  assign shifted  = sum >>> FRAC_BITS;

  always_comb begin
    hid_act = '0;
    if (!sum[ACC_WIDTH-1]) begin
      if (shifted > HID_MAX) hid_act = HID_MAX[DATA_WIDTH-1:0];
      else                   hid_act = shifted[DATA_WIDTH-1:0];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    fetch      = 1'b0;
    fin        = 1'b0;
    layer_done = 1'b0;
    out_fire   = 1'b0;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        accept = bus.in_valid && in_ready_q;
        if (accept) state_d = last_in ? S_L1 : S_LOAD;
      end
      S_L1, S_L2: begin
        fetch      = (tap_q < fin_tap);
        fin        = (tap_q == fin_tap);
        layer_done = fin && (neu_q == layer_last);
        if (layer_done) state_d = (state_q == S_L1) ? S_L2 : S_OUT;
      end
      S_OUT: begin
        out_fire = out_valid_q && bus.out_ready;
        if (out_fire && out_last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      in_cnt_q    <= '0;
      tap_q       <= '0;
      neu_q       <= '0;
      out_cnt_q   <= '0;
      ptr_q       <= '0;
      last_addr_q <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD);

      if (accept) in_cnt_q <= last_in ? '0 : in_cnt_q + 1'b1;
      if (state_q == S_IDLE) ptr_q <= '0;

      if (in_layer) begin
        if (fin) begin
          tap_q <= '0;
          neu_q <= layer_done ? '0 : neu_q + 1'b1;
        end else begin
          tap_q <= tap_q + 1'b1;
        end
        if (fetch) begin
          ptr_q       <= ptr_q + 1'b1;
          last_addr_q <= ptr_q;
        end
        if (tap_q == '0)  acc_q <= '0;
        else if (!fin)    acc_q <= acc_q + prod_ext;
      end

      // The first OUT cycle only primes the output register, hence one cycle of extra latency.
      if (state_q == S_OUT) begin
        if (!out_valid_q) begin
          out_valid_q <= 1'b1;
          out_cnt_q   <= '0;
          out_data_q  <= out_buf[0];
          out_last_q  <= (OUT_IDX_LAST == '0);
        end else if (out_fire) begin
          if (out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_cnt_q   <= '0;
          end else begin
            out_cnt_q  <= out_nxt;
            out_data_q <= out_buf[out_nxt];
            out_last_q <= (out_nxt == OUT_IDX_LAST);
          end
        end
      end
    end
  end

  // NOTE: the buffers carry no reset; every entry is rewritten before it is read for a sample.
  always_ff @(posedge clk) begin
    if (accept) in_buf[in_cnt_q] <= bus.in_data;
    if (fin && (state_q == S_L1)) hid_buf[HID_IW'(neu_q)] <= hid_act;
    if (fin && (state_q == S_L2)) out_buf[OUT_IW'(neu_q)] <= sum;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.w_rd_en   = fetch;
  assign bus.w_addr    = fetch ? ptr_q : last_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != S_IDLE);

`ifdef NN_ARGMAX_EN
  logic signed [ACC_WIDTH-1:0] best_q;
  logic [OUT_IW-1:0]           argmax_idx_q;
  logic                        argmax_valid_q;

  // Strict greater-than keeps the lower index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q         <= '0;
      argmax_idx_q   <= '0;
      argmax_valid_q <= 1'b0;
    end else begin
      argmax_valid_q <= (state_q == S_OUT) && !out_valid_q;
      if (fin && (state_q == S_L2) && ((neu_q == '0) || (sum > best_q))) begin
        best_q       <= sum;
        argmax_idx_q <= OUT_IW'(neu_q);
      end
    end
  end

  assign bus.argmax_valid = argmax_valid_q;
  assign bus.argmax_idx   = argmax_idx_q;
`endif
endmodule

// File: tb/tb_nn_mlp_seq.sv
// Directed bench for nn_mlp_seq with a reference model feeding an expected-output queue.
// Argmax checks are included when NN_ARGMAX_EN is defined.
module tb_nn_mlp_seq;
  localparam int DW       = 16;
  localparam int FB       = 8;
  localparam int AW       = 40;
  localparam int IN_NUM   = 4;
  localparam int HID_NUM  = 2;
  localparam int OUT_NUM  = 2;
  localparam int WORDS    = HID_NUM*(IN_NUM+1) + OUT_NUM*(HID_NUM+1);
  localparam int WADDR_W  = $clog2(WORDS);
  localparam int L2_BASE  = HID_NUM*(IN_NUM+1);
  localparam int LATENCY  = 1 + HID_NUM*(IN_NUM+2) + OUT_NUM*(HID_NUM+2);
  localparam int AM_W     = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

  typedef struct {
    logic [AW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nn_mlp_seq_if #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .WADDR_W(WADDR_W)
`ifdef NN_ARGMAX_EN
    , .IDX_W(AM_W)
`endif
  ) bus ();

  nn_mlp_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(AW),
    .IN_NUM(IN_NUM), .HID_NUM(HID_NUM), .OUT_NUM(OUT_NUM), .WADDR_W(WADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec   = 0;
  int n_fail  = 0;
  int n_fetch = 0;
  int n_am    = 0;
  int exp_idx = 0;
  exp_t exp_q[$];
  logic signed [DW-1:0] xin  [IN_NUM];
  logic signed [DW-1:0] wmem [WORDS];

  // Synchronous weight memory: data one cycle after the read strobe.
  always @(posedge clk) if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];

  always @(negedge clk) begin
    if (bus.w_rd_en) n_fetch++;
`ifdef NN_ARGMAX_EN
    if (bus.argmax_valid) n_am++;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input int v);
    for (int i = 0; i < IN_NUM; i++) xin[i] = DW'(v);
  endtask

  task automatic set_weights(input int w1, input int b1, input int w2, input int b2a, input int b2b);
    for (int n = 0; n < HID_NUM; n++) begin
      for (int i = 0; i < IN_NUM; i++) wmem[n*(IN_NUM+1)+i] = DW'(w1);
      wmem[n*(IN_NUM+1)+IN_NUM] = DW'(b1);
    end
    for (int m = 0; m < OUT_NUM; m++) begin
      for (int j = 0; j < HID_NUM; j++) wmem[L2_BASE+m*(HID_NUM+1)+j] = DW'(w2);
      wmem[L2_BASE+m*(HID_NUM+1)+HID_NUM] = (m == 0) ? DW'(b2a) : DW'(b2b);
    end
  endtask

  task automatic set_random();
    int v;
    for (int i = 0; i < IN_NUM; i++) begin
      v = int'($urandom_range(600)) - 300;
      xin[i] = v[DW-1:0];
    end
    for (int a = 0; a < WORDS; a++) begin
      v = int'($urandom_range(400)) - 200;
      wmem[a] = v[DW-1:0];
    end
  endtask

  // Reference model: integer arithmetic, floor division for the requantising shift.
  task automatic build_expect();
    longint acc;
    longint best;
    longint h [HID_NUM];
    exp_t e;
    best = 0;
    for (int n = 0; n < HID_NUM; n++) begin
      acc = 0;
      for (int i = 0; i < IN_NUM; i++)
        acc += longint'(xin[i]) * longint'(wmem[n*(IN_NUM+1)+i]);
      acc += longint'(wmem[n*(IN_NUM+1)+IN_NUM]) * (64'sd1 << FB);
      if (acc < 0)                                h[n] = 0;
      else if (acc / (64'sd1 << FB) > 32767)      h[n] = 32767;
      else                                        h[n] = acc / (64'sd1 << FB);
    end
    for (int m = 0; m < OUT_NUM; m++) begin
      acc = 0;
      for (int j = 0; j < HID_NUM; j++)
        acc += h[j] * longint'(wmem[L2_BASE+m*(HID_NUM+1)+j]);
      acc += longint'(wmem[L2_BASE+m*(HID_NUM+1)+HID_NUM]) * (64'sd1 << FB);
      e.data = acc[AW-1:0];
      e.last = (m == OUT_NUM-1);
      exp_q.push_back(e);
      if (m == 0 || acc > best) begin
        best    = acc;
        exp_idx = m;
      end
    end
  endtask

  // Returns #1 after the posedge carrying the last input handshake.
  task automatic drive_inputs();
    int g;
    for (int i = 0; i < IN_NUM; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = xin[i];
      g = 0;
      while (!bus.in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("in_ready_wait", bus.in_ready, 1);
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic run_sample(input int stall);
    int lat;
    int g;
    exp_t e;
    n_fetch = 0;
    n_am    = 0;
    build_expect();
    drive_inputs();
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, LATENCY);
`ifdef NN_ARGMAX_EN
    check("argmax_valid_first", bus.argmax_valid, 1);
`endif
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check("stall_valid", bus.out_valid, 1);
      check("stall_data", bus.out_data, exp_q[0].data);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < OUT_NUM; k++) begin
      g = 0;
      while (!bus.out_valid && g < 50) begin
        @(posedge clk);
        #1;
        g++;
      end
      e = exp_q.pop_front();
      check("out_data", bus.out_data, e.data);
      check("out_last", bus.out_last, e.last);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    check("done_out_valid", bus.out_valid, 0);
    check("done_busy", bus.busy, 0);
    check("w_addr_hold", bus.w_addr, WORDS-1);
    check("fetch_count", n_fetch, WORDS);
`ifdef NN_ARGMAX_EN
    check("argmax_pulses", n_am, 1);
    check("argmax_idx", bus.argmax_idx, exp_idx);
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.w_data    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_w_rd_en", bus.w_rd_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_last", bus.out_last, 0);
`ifdef NN_ARGMAX_EN
    check("rst_argmax_valid", bus.argmax_valid, 0);
    check("rst_argmax_idx", bus.argmax_idx, 0);
`endif
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    // Basic inference: hidden 512, outputs 262144.
    set_inputs(256);
    set_weights(128, 0, 256, 0, 0);
    run_sample(0);

    // ReLU clamps hidden to 0; L2 bias alone gives 65536.
    set_weights(-128, 0, 256, 256, 256);
    run_sample(0);

    // Saturation of hidden to 32767.
    set_inputs(32767);
    set_weights(32767, 0, 256, 0, 0);
    run_sample(0);

    // Backpressure: outputs held for 5 cycles.
    set_inputs(256);
    set_weights(128, 0, 256, 0, 0);
    run_sample(5);

    // Reset in the middle of L1, then a clean basic run.
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_w_rd_en", bus.w_rd_en, 0);
    check("midrst_busy", bus.busy, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    run_sample(0);

    // Mixed-sign values exercise addressing, operand order and ReLU per neuron.
    set_random();
    run_sample(0);
    set_random();
    run_sample(2);

    // Distinct L2 biases select neuron 1; equal biases tie to neuron 0.
    set_inputs(256);
    set_weights(128, 0, 256, 0, 512);
    run_sample(0);
    set_weights(128, 0, 256, 0, 0);
    run_sample(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
